// File: rtl/lut_neuron_loader.sv
// Runtime-loadable LUT neuron: a config stream fills a 2^IN_BITS x OUT_BITS table in index
// order, after which the block serves registered one-cycle lookups.
module lut_neuron_loader #(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic                loaded,
  input  logic [IN_BITS-1:0]  M0,
  input  logic                in_valid,
  output logic [OUT_BITS-1:0] M1,
  output logic                out_valid
);

  localparam int unsigned Depth = 2 ** IN_BITS;

  typedef enum logic [1:0] {StEmpty, StLoad, StReady} state_e;

  state_e                state_q;
  logic [IN_BITS-1:0]    idx_q;
  logic                  cfg_ready_q;
  logic                  loaded_q;
  logic                  out_valid_q;
  logic [OUT_BITS-1:0]   m1_q;
  logic [OUT_BITS-1:0]   mem_q [Depth];

  logic                  wr_en;
  logic                  rd_en;
  logic                  last_beat;

  // cfg_start has priority over a beat or a lookup landing on the same edge.
  assign wr_en     = (state_q == StLoad) && cfg_valid && !cfg_start;
  assign rd_en     = (state_q == StReady) && in_valid && !cfg_start;
  assign last_beat = wr_en && (idx_q == {IN_BITS{1'b1}});

  // Table storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx_q] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      idx_q       <= '0;
      cfg_ready_q <= 1'b0;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
      m1_q        <= '0;
    end else begin
      out_valid_q <= rd_en;
      if (rd_en) begin
        m1_q <= mem_q[M0];
      end
      if (cfg_start) begin
        state_q     <= StLoad;
        idx_q       <= '0;
        cfg_ready_q <= 1'b1;
        loaded_q    <= 1'b0;
      end else if (wr_en) begin
        idx_q <= idx_q + {{(IN_BITS-1){1'b0}}, 1'b1};
        if (last_beat) begin
          state_q     <= StReady;
          cfg_ready_q <= 1'b0;
          loaded_q    <= 1'b1;
        end
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign loaded    = loaded_q;
  assign M1        = m1_q;
  assign out_valid = out_valid_q;

endmodule
